// File: rtl/ge_checker.sv
// ge_checker: self-contained stimulus source and response checker for a `ge` comparator.
// Latency: vector k is driven after edge k; its dut_z is compared at edge k+LATENCY+1.
// Backpressure: none. The comparator must accept one vector per cycle; start is ignored while busy.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, count      begin a run of 8 corner vectors followed by `count` LFSR vectors
//   busy, done, pass  run status; pass is meaningful while done=1
//   dut_a, dut_b      operands to the comparator; dut_z is its result
//   error_count       saturating mismatch count for this run
//   first_fail_*      index of the first mismatching vector of this run
module ge_checker #(
  parameter int          LATENCY = 1,
  parameter bit          SIGNED  = 1'b1,
  parameter logic [31:0] SEED_A  = 32'h0000_0001,
  parameter logic [31:0] SEED_B  = 32'h0000_ACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] count,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] dut_a,
  output logic [31:0] dut_b,
  input  logic        dut_z,
  output logic [31:0] error_count,
  output logic        first_fail_valid,
  output logic [31:0] first_fail_index
);

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [31:0] INIT_A = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [31:0] INIT_B = (SEED_B == 32'd0) ? 32'd1 : SEED_B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORNER,
    S_RANDOM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0] lfsr_a, lfsr_b;
  logic [31:0] vec_idx;     // index of the next vector to issue (wraps)
  logic [31:0] remaining;   // random vectors still to issue

  // Check pipeline: stage 0 holds the vector issued at the last edge,
  // stage LATENCY lines up with the dut_z being sampled now.
  logic [LATENCY:0] p_vld, p_exp, p_last;
  logic [31:0]      p_idx [0:LATENCY];

  logic        start_run, sample, mismatch, finish;
  logic        issue, issue_last;
  logic [31:0] issue_idx, nxt_a, nxt_b;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [63:0] corner_vec(input logic [2:0] i);
    case (i)
      3'd0:    corner_vec = {32'h0000_0000, 32'h0000_0000};
      3'd1:    corner_vec = {32'h0000_0001, 32'h0000_0000};
      3'd2:    corner_vec = {32'h0000_0000, 32'h0000_0001};
      3'd3:    corner_vec = {32'h7FFF_FFFF, 32'h8000_0000};
      3'd4:    corner_vec = {32'h8000_0000, 32'h7FFF_FFFF};
      3'd5:    corner_vec = {32'hFFFF_FFFF, 32'h0000_0000};
      3'd6:    corner_vec = {32'h0000_0000, 32'hFFFF_FFFF};
      default: corner_vec = {32'h8000_0000, 32'h8000_0000};
    endcase
  endfunction

  function automatic logic expect_ge(input logic [31:0] a, input logic [31:0] b);
    if (SIGNED) expect_ge = ($signed(a) >= $signed(b));
    else        expect_ge = (a >= b);
  endfunction

  assign start_run = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign sample    = p_vld[LATENCY];
  assign mismatch  = sample && (dut_z != p_exp[LATENCY]);
  assign finish    = sample && p_last[LATENCY];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_idx  = vec_idx;
    nxt_a      = dut_a;
    nxt_b      = dut_b;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_CORNER;
          issue          = 1'b1;
          issue_idx      = 32'd0;
          {nxt_a, nxt_b} = corner_vec(3'd0);
        end
      end
      S_CORNER: begin
        issue          = 1'b1;
        {nxt_a, nxt_b} = corner_vec(vec_idx[2:0]);
        if (vec_idx[2:0] == 3'd7) begin
          // remaining still equals the latched count here
          if (remaining != 32'd0) begin
            state_nxt = S_RANDOM;
          end else begin
            state_nxt  = S_DRAIN;
            issue_last = 1'b1;
          end
        end
      end
      S_RANDOM: begin
        issue = 1'b1;
        nxt_a = lfsr_a;
        nxt_b = lfsr_b;
        if (remaining == 32'd1) begin
          state_nxt  = S_DRAIN;
          issue_last = 1'b1;
        end
      end
      S_DRAIN: begin
        if (finish) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      dut_a            <= 32'd0;
      dut_b            <= 32'd0;
      error_count      <= 32'd0;
      first_fail_valid <= 1'b0;
      first_fail_index <= 32'd0;
      lfsr_a           <= INIT_A;
      lfsr_b           <= INIT_B;
      vec_idx          <= 32'd0;
      remaining        <= 32'd0;
      p_vld            <= '0;
      p_exp            <= '0;
      p_last           <= '0;
      for (int i = 0; i <= LATENCY; i++) p_idx[i] <= 32'd0;
    end else begin
      dut_a  <= nxt_a;
      dut_b  <= nxt_b;
      p_vld  <= {p_vld[LATENCY-1:0], issue};
      p_exp  <= {p_exp[LATENCY-1:0], expect_ge(nxt_a, nxt_b)};
      p_last <= {p_last[LATENCY-1:0], issue_last};
      p_idx[0] <= issue_idx;
      for (int i = 1; i <= LATENCY; i++) p_idx[i] <= p_idx[i-1];

      if (start_run) begin
        busy             <= 1'b1;
        done             <= 1'b0;
        pass             <= 1'b0;
        error_count      <= 32'd0;
        first_fail_valid <= 1'b0;
        first_fail_index <= 32'd0;
        remaining        <= count;
        vec_idx          <= 32'd1;
        // Reload so every run replays the same random sequence.
        lfsr_a           <= INIT_A;
        lfsr_b           <= INIT_B;
      end else begin
        if (mismatch) begin
          if (error_count != 32'hFFFF_FFFF) error_count <= error_count + 32'd1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_index <= p_idx[LATENCY];
          end
        end
        if ((state == S_CORNER) || (state == S_RANDOM)) vec_idx <= vec_idx + 32'd1;
        if (state == S_RANDOM) begin
          remaining <= remaining - 32'd1;
          lfsr_a    <= lfsr_step(lfsr_a);
          lfsr_b    <= lfsr_step(lfsr_b);
        end
        if ((state == S_DRAIN) && finish) begin
          busy <= 1'b0;
          done <= 1'b1;
          // Include the compare made at this very edge.
          pass <= (error_count == 32'd0) && !mismatch;
        end
      end
    end
  end

endmodule

// File: tb/tb_ge_checker.sv
// Bench for ge_checker: three checker instances driving behavioural comparators
// (signed L=1 with selectable fault behaviour, unsigned L=1, signed L=3),
// compared against a vector-list reference model built from the operand rules.
module tb_ge_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [3];
  logic [31:0] cnt_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        z_v     [3];
  logic [31:0] ec_v    [3];
  logic        ffv_v   [3];
  logic [31:0] ffi_v   [3];

  int errs   = 0;
  int checks = 0;

  ge_checker #(.LATENCY(1), .SIGNED(1'b1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .count(cnt_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_z(z_v[0]),
    .error_count(ec_v[0]), .first_fail_valid(ffv_v[0]), .first_fail_index(ffi_v[0]));

  ge_checker #(.LATENCY(1), .SIGNED(1'b0)) u_u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .count(cnt_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_z(z_v[1]),
    .error_count(ec_v[1]), .first_fail_valid(ffv_v[1]), .first_fail_index(ffi_v[1]));

  ge_checker #(.LATENCY(3), .SIGNED(1'b1)) u_s3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .count(cnt_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_z(z_v[2]),
    .error_count(ec_v[2]), .first_fail_valid(ffv_v[2]), .first_fail_index(ffi_v[2]));

  // Comparator behaviour for instance 0: 0 = signed ge, 1 = stuck at 0, 2 = unsigned ge,
  // with optional per-vector inverted results.
  int   zmode = 0;
  int   vcnt  = 0;
  bit   flip [0:4095];
  logic [1:0] z3pipe;

  function automatic logic zfun(input int mode, input logic [31:0] a, input logic [31:0] b);
    if (mode == 0)      zfun = ($signed(a) >= $signed(b));
    else if (mode == 1) zfun = 1'b0;
    else                zfun = (a >= b);
  endfunction

  always @(posedge clk) begin
    z_v[0] <= zfun(zmode, a_v[0], b_v[0]) ^ ((vcnt >= 0 && vcnt < 4096) ? flip[vcnt] : 1'b0);
    if (start_v[0] && !busy_v[0]) vcnt <= 0;
    else                          vcnt <= vcnt + 1;
    z_v[1]  <= (a_v[1] >= b_v[1]);
    z3pipe  <= {z3pipe[0], ($signed(a_v[2]) >= $signed(b_v[2]))};
    z_v[2]  <= z3pipe[1];
  end

  // Reference vector list for one run.
  logic [31:0] va[$];
  logic [31:0] vb[$];

  task automatic build_model(input int cnt);
    logic [31:0] sa, sb;
    va = {32'h0, 32'h1, 32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vb = {32'h0, 32'h0, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h80000000};
    sa = 32'h1;
    sb = 32'hACE1;
    for (int i = 0; i < cnt; i++) begin
      va.push_back(sa);
      vb.push_back(sb);
      sa = {sa[30:0], sa[31] ^ sa[21] ^ sa[1] ^ sa[0]};
      sb = {sb[30:0], sb[31] ^ sb[21] ^ sb[1] ^ sb[0]};
    end
  endtask

  // Mismatches expected for instance-0 comparator behaviour against a checker of the given signedness.
  function automatic int model_err(input int mode, input bit use_signed, output int first);
    int  n;
    logic r, z;
    n = 0;
    first = -1;
    for (int i = 0; i < va.size(); i++) begin
      r = use_signed ? ($signed(va[i]) >= $signed(vb[i])) : (va[i] >= vb[i]);
      z = zfun(mode, va[i], vb[i]) ^ ((i < 4096) ? flip[i] : 1'b0);
      if (z != r) begin
        if (n == 0) first = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic clear_flips();
    for (int i = 0; i < 4096; i++) flip[i] = 1'b0;
  endtask

  // Starts a run on instance w and follows it to done (bounded), collecting observations.
  task automatic run(input int w, input int cnt, output int busy_cyc, output int vec_bad,
                     output logic [31:0] a8, output logic [31:0] b8, output bit to);
    int k;
    build_model(cnt);
    start_v[w] = 1'b1;
    cnt_v[w]   = 32'(cnt);
    @(posedge clk); #1;
    start_v[w] = 1'b0;
    busy_cyc = 0; vec_bad = 0; k = 0; a8 = 'x; b8 = 'x;
    while (done_v[w] !== 1'b1 && k < 20000) begin
      if (busy_v[w] === 1'b1) busy_cyc++;
      if (k < va.size()) begin
        if (a_v[w] !== va[k] || b_v[w] !== vb[k]) vec_bad++;
      end
      if (k == 8) begin a8 = a_v[w]; b8 = b_v[w]; end
      @(posedge clk); #1;
      k++;
    end
    to = (done_v[w] !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int w = 0; w < 3; w++) begin start_v[w] = 1'b0; cnt_v[w] = 32'd0; end
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({busy_v[w], done_v[w], pass_v[w], ffv_v[w]} !== 4'b0 ||
          {ec_v[w], ffi_v[w], a_v[w], b_v[w]} !== 128'd0) begin
        errs++;
        $display("FAIL reset inst%0d: busy=%b done=%b pass=%b ffv=%b ec=%h ffi=%h a=%h b=%h, want all 0",
                 w, busy_v[w], done_v[w], pass_v[w], ffv_v[w], ec_v[w], ffi_v[w], a_v[w], b_v[w]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_golden_l1();
    int bc, vb_; logic [31:0] a8, b8; bit to;
    zmode = 0; clear_flips();
    run(0, 0, bc, vb_, a8, b8, to);
    checks++; if (to) begin errs++; $display("FAIL golden_l1 timeout: done never rose"); end
    checks++; if (bc != 9) begin errs++; $display("FAIL golden_l1 busy_cycles: got %0d want 9", bc); end
    checks++; if (ec_v[0] !== 32'd0 || pass_v[0] !== 1'b1 || ffv_v[0] !== 1'b0) begin
      errs++; $display("FAIL golden_l1 status: ec=%0d pass=%b ffv=%b want 0/1/0", ec_v[0], pass_v[0], ffv_v[0]);
    end
    checks++; if (vb_ != 0) begin errs++; $display("FAIL golden_l1 vectors: %0d wrong, want 0", vb_); end
  endtask

  task automatic test_long_run();
    int bc, vb_; logic [31:0] a8, b8; bit to;
    zmode = 0; clear_flips();
    run(0, 1000, bc, vb_, a8, b8, to);
    checks++; if (to) begin errs++; $display("FAIL long timeout: done never rose"); end
    checks++; if (bc != 1009) begin errs++; $display("FAIL long busy_cycles: got %0d want 1009", bc); end
    checks++; if (a8 !== 32'h0000_0001 || b8 !== 32'h0000_ACE1) begin
      errs++; $display("FAIL long vec8: got %h/%h want 00000001/0000ace1", a8, b8);
    end
    checks++; if (vb_ != 0) begin errs++; $display("FAIL long vectors: %0d wrong, want 0", vb_); end
    checks++; if (ec_v[0] !== 32'd0 || pass_v[0] !== 1'b1) begin
      errs++; $display("FAIL long status: ec=%0d pass=%b want 0/1", ec_v[0], pass_v[0]);
    end
  endtask

  task automatic test_stuck_zero();
    int bc, vb_, exp_n, exp_f; logic [31:0] a8, b8; bit to;
    zmode = 1; clear_flips();
    run(0, 0, bc, vb_, a8, b8, to);
    exp_n = model_err(1, 1'b1, exp_f);
    checks++; if (to) begin errs++; $display("FAIL stuck0 timeout: done never rose"); end
    checks++; if (ec_v[0] !== 32'(exp_n)) begin errs++; $display("FAIL stuck0 error_count: got %0d want %0d", ec_v[0], exp_n); end
    checks++; if (ffv_v[0] !== 1'b1 || ffi_v[0] !== 32'(exp_f)) begin
      errs++; $display("FAIL stuck0 first_fail: got v=%b i=%0d want 1/%0d", ffv_v[0], ffi_v[0], exp_f);
    end
    checks++; if (pass_v[0] !== 1'b0 || done_v[0] !== 1'b1) begin errs++; $display("FAIL stuck0 pass/done: got %b/%b want 0/1", pass_v[0], done_v[0]); end
  endtask

  task automatic test_unsigned();
    int bc, vb_, exp_n, exp_f, cnt; logic [31:0] a8, b8; bit to;
    run(1, 0, bc, vb_, a8, b8, to);
    checks++; if (to || ec_v[1] !== 32'd0 || pass_v[1] !== 1'b1 || vb_ != 0) begin
      errs++; $display("FAIL unsigned_golden: to=%b ec=%0d pass=%b badvec=%0d want 0/0/1/0", to, ec_v[1], pass_v[1], vb_);
    end
    cnt = $urandom_range(1, 300);
    run(1, cnt, bc, vb_, a8, b8, to);
    checks++; if (to || ec_v[1] !== 32'd0 || bc != cnt + 9 || vb_ != 0) begin
      errs++; $display("FAIL unsigned_rand cnt=%0d: to=%b ec=%0d busy=%0d badvec=%0d want 0/0/%0d/0", cnt, to, ec_v[1], bc, vb_, cnt + 9);
    end
    // Unsigned comparator behind the signed checker.
    zmode = 2; clear_flips();
    run(0, 0, bc, vb_, a8, b8, to);
    exp_n = model_err(2, 1'b1, exp_f);
    checks++; if (to || ec_v[0] !== 32'(exp_n) || ffi_v[0] !== 32'(exp_f)) begin
      errs++; $display("FAIL signed_vs_unsigned: to=%b ec=%0d ffi=%0d want 0/%0d/%0d", to, ec_v[0], ffi_v[0], exp_n, exp_f);
    end
  endtask

  task automatic test_reset_midrun();
    int bc, vb_; logic [31:0] a8, b8; bit to;
    zmode = 1; clear_flips();
    start_v[0] = 1'b1; cnt_v[0] = 32'd100;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy_v[0] !== 1'b1 || ec_v[0] === 32'd0) begin
      errs++; $display("FAIL midrun_pre: busy=%b ec=%0d want busy=1 ec>0", busy_v[0], ec_v[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy_v[0], done_v[0], pass_v[0], ffv_v[0]} !== 4'b0 ||
                  {ec_v[0], ffi_v[0], a_v[0], b_v[0]} !== 128'd0) begin
      errs++; $display("FAIL midrun_reset: busy=%b done=%b pass=%b ffv=%b ec=%h ffi=%h a=%h b=%h want all 0",
                       busy_v[0], done_v[0], pass_v[0], ffv_v[0], ec_v[0], ffi_v[0], a_v[0], b_v[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || a_v[0] !== 32'd0) begin
      errs++; $display("FAIL midrun_idle: busy=%b done=%b a=%h want 0/0/0", busy_v[0], done_v[0], a_v[0]);
    end
    zmode = 0;
    run(0, 100, bc, vb_, a8, b8, to);
    checks++; if (to || ec_v[0] !== 32'd0 || pass_v[0] !== 1'b1 || bc != 109 || vb_ != 0) begin
      errs++; $display("FAIL midrun_rerun: to=%b ec=%0d pass=%b busy=%0d badvec=%0d want 0/0/1/109/0", to, ec_v[0], pass_v[0], bc, vb_);
    end
  endtask

  task automatic test_start_held();
    int bc, k;
    zmode = 1; clear_flips();
    start_v[0] = 1'b1; cnt_v[0] = 32'd0;
    @(posedge clk); #1;
    bc = 0; k = 0;
    while (done_v[0] !== 1'b1 && k < 200) begin
      if (busy_v[0] === 1'b1) bc++;
      @(posedge clk); #1;
      k++;
    end
    checks++; if (done_v[0] !== 1'b1 || bc != 9) begin
      errs++; $display("FAIL start_held run: done=%b busy=%0d want 1/9", done_v[0], bc);
    end
    checks++; if (ec_v[0] !== 32'd5) begin errs++; $display("FAIL start_held errors: got %0d want 5", ec_v[0]); end
    // start still high in DONE: the next edge restarts
    zmode = 0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    checks++; if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || ec_v[0] !== 32'd0 || ffv_v[0] !== 1'b0) begin
      errs++; $display("FAIL restart_edge: done=%b busy=%b ec=%0d ffv=%b want 0/1/0/0", done_v[0], busy_v[0], ec_v[0], ffv_v[0]);
    end
    bc = 0; k = 0;
    while (done_v[0] !== 1'b1 && k < 200) begin
      if (busy_v[0] === 1'b1) bc++;
      @(posedge clk); #1;
      k++;
    end
    checks++; if (done_v[0] !== 1'b1 || bc != 9 || pass_v[0] !== 1'b1 || ec_v[0] !== 32'd0) begin
      errs++; $display("FAIL restart_run: done=%b busy=%0d pass=%b ec=%0d want 1/9/1/0", done_v[0], bc, pass_v[0], ec_v[0]);
    end
  endtask

  task automatic test_latency3();
    int bc, vb_, cnt; logic [31:0] a8, b8; bit to;
    run(2, 0, bc, vb_, a8, b8, to);
    checks++; if (to || bc != 11 || pass_v[2] !== 1'b1 || ec_v[2] !== 32'd0) begin
      errs++; $display("FAIL lat3: to=%b busy=%0d pass=%b ec=%0d want 0/11/1/0", to, bc, pass_v[2], ec_v[2]);
    end
    cnt = $urandom_range(1, 200);
    run(2, cnt, bc, vb_, a8, b8, to);
    checks++; if (to || bc != cnt + 11 || pass_v[2] !== 1'b1 || vb_ != 0) begin
      errs++; $display("FAIL lat3_rand cnt=%0d: to=%b busy=%0d pass=%b badvec=%0d want 0/%0d/1/0", cnt, to, bc, pass_v[2], vb_, cnt + 11);
    end
  endtask

  task automatic test_random_errors();
    int bc, vb_, cnt, n, nflip, exp_n, exp_f; logic [31:0] a8, b8; bit to;
    zmode = 0;
    for (int r = 0; r < 5; r++) begin
      clear_flips();
      cnt   = $urandom_range(0, 150);
      n     = cnt + 8;
      nflip = $urandom_range(0, 4);
      for (int j = 0; j < nflip; j++) flip[$urandom_range(0, n - 1)] = 1'b1;
      run(0, cnt, bc, vb_, a8, b8, to);
      exp_n = model_err(0, 1'b1, exp_f);
      checks++; if (to || bc != n + 1 || vb_ != 0) begin
        errs++; $display("FAIL rand%0d run: to=%b busy=%0d badvec=%0d want 0/%0d/0", r, to, bc, vb_, n + 1);
      end
      checks++; if (ec_v[0] !== 32'(exp_n) || pass_v[0] !== (exp_n == 0)) begin
        errs++; $display("FAIL rand%0d errors: ec=%0d pass=%b want %0d/%b", r, ec_v[0], pass_v[0], exp_n, exp_n == 0);
      end
      checks++; if (ffv_v[0] !== (exp_n != 0) || (exp_n != 0 && ffi_v[0] !== 32'(exp_f))) begin
        errs++; $display("FAIL rand%0d first_fail: v=%b i=%0d want %b/%0d", r, ffv_v[0], ffi_v[0], exp_n != 0, exp_f);
      end
    end
    clear_flips();
  endtask

  initial begin
    clear_flips();
    z3pipe = 2'b00;
    test_reset();
    test_golden_l1();
    test_long_run();
    test_stuck_zero();
    test_unsigned();
    test_reset_midrun();
    test_start_held();
    test_latency3();
    test_random_errors();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ge_checker.md
Name: ge_checker

Overview:
- Hardware stimulus source and response checker for the `ge` comparator interface.
- Drives `a`/`b` operand vectors into a `ge` instance: first a fixed corner-case set, then a run of pseudo-random vectors from LFSRs.
- Captures `z` after the comparator's pipeline latency and checks it against an internally computed expected result.
- Reports the error count and the first failing vector index, giving on-chip/self-checking coverage that does not depend on stimulus files.

Parameters:
- LATENCY, 1: cycles from operands valid on dut_a/dut_b to the matching result valid on dut_z. Legal range 1..8.
- SIGNED, 1: 1 = two's-complement compare (a >= b signed); 0 = unsigned compare.
- SEED_A, 32'h00000001: LFSR seed for operand a. A seed of 0 is replaced by 1.
- SEED_B, 32'h0000ACE1: LFSR seed for operand b. A seed of 0 is replaced by 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- count  input  32  number of random vectors; sampled with start
- busy  output  1  run in progress
- done  output  1  run complete; held until next start or rst
- pass  output  1  valid when done=1; 1 iff error_count==0
- dut_a  output  32  operand a to comparator
- dut_b  output  32  operand b to comparator
- dut_z  input  1  comparator result
- error_count  output  32  mismatches this run, saturates at 32'hFFFFFFFF
- first_fail_valid  output  1  at least one mismatch this run
- first_fail_index  output  32  index of first mismatching vector

Behaviour:
- Reset (rst=1 at an edge, any state, mid-run included):
  - state=IDLE.
  - busy, done, pass, first_fail_valid = 0.
  - error_count, first_fail_index, dut_a, dut_b = 0.
  - LFSRs reloaded to seeds; check pipeline cleared.
- States: IDLE, CORNER, RANDOM, DRAIN, DONE.
- IDLE/DONE, start=1:
  - Latch count; clear error_count, first_fail_*, done, pass.
  - busy=1; load vector 0 onto dut_a/dut_b at the same edge.
  - Go to CORNER.
- start while busy is ignored.
- CORNER: one vector per edge, indices 0..7, in this order:
  - (0,0), (1,0), (0,1)
  - (7FFFFFFF,80000000), (80000000,7FFFFFFF)
  - (FFFFFFFF,0), (0,FFFFFFFF), (80000000,80000000)
  - After index 7: go to RANDOM if count>0, else DRAIN.
- RANDOM:
  - Vector index 8+i uses the current LFSR values, then both LFSRs advance.
  - First random vector = (SEED_A, SEED_B).
  - LFSR: shift left; new bit0 = s[31]^s[21]^s[1]^s[0].
  - After the count-th random vector: go to DRAIN.
- Timing: a vector applied during cycle k (after edge k) has its dut_z valid during cycle k+LATENCY. The checker samples at edge k+LATENCY+1.
  - Implement as a valid/expected/index shift register of depth LATENCY+1.
- Expected result:
  - SIGNED=1: $signed(a) >= $signed(b).
  - SIGNED=0: a >= b.
  - Computed when the vector is issued.
- On a sample with dut_z != expected:
  - error_count += 1 (saturating).
  - If first_fail_valid=0: set first_fail_valid=1 and capture the index.
- DRAIN:
  - dut_a/dut_b hold their last value; no new valid entries are issued.
  - Leaves DRAIN at the edge that samples the last vector: busy=0, done=1, pass=(final error_count==0).
  - That edge's compare is included in error_count.
- Run length: total vectors N = 8 + count. busy is high for N+LATENCY cycles.
- count = 32'hFFFFFFFF is legal. The vector index counter is 32-bit and wraps silently; first_fail_index wraps with it.

Test Plan:
1. Golden registered ge (LATENCY=1, SIGNED=1), count=0, start pulse at edge e0:
   - busy high 9 cycles; done=1 after edge e9.
   - error_count=0, pass=1, first_fail_valid=0.
2. Golden DUT, count=1000:
   - done after exactly 1009 busy cycles; error_count=0, pass=1.
   - dut_a/dut_b at vector index 8 equal 00000001/0000ACE1.
3. dut_z tied 0, count=0:
   - Expected corner results are 1,1,0,1,0,0,1,1.
   - error_count=5, first_fail_valid=1, first_fail_index=0, pass=0.
4. SIGNED=0, golden unsigned DUT, count=0:
   - Vector 3 (7FFFFFFF,80000000) expects 0; vector 5 (FFFFFFFF,0) expects 1; error_count=0.
   - The same unsigned DUT checked with SIGNED=1 gives error_count=4.
5. Reset mid-run:
   - rst asserted at random index 20 of count=100. The next cycle shows all outputs at reset values and state IDLE.
   - A new start gives a full clean run with error_count=0.
6. Start handling and LATENCY:
   - start held high throughout a run has no effect while busy.
   - start in DONE restarts, clearing error_count and done at that edge.
   - Repeat test 1 with LATENCY=3 and a 3-stage golden DUT: busy 11 cycles, pass=1.
